// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
//   Bundle of the signals between the mul/div issue scheduler and the blocks
//   around it: the reservation-station requesters, the shared mul/div
//   datapath, the common data bus (CDB) and the branch-flush source.
//
//   Requester side : req_valid, req_op, req_cls, req_tag  -> grant
//   Datapath side  : start, start_op, unit_kill
//   CDB side       : cdb_gnt -> cdb_req, cdb_tag
//   Misc           : flush in, busy out
//
//   modport slave  : the scheduler itself
//   modport master : whatever drives the scheduler (pipeline or testbench)
// ---------------------------------------------------------------------------
interface muldiv_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int OP_W    = 5
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*OP_W-1:0]  req_op;
    logic [NUM_REQ*2-1:0]     req_cls;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     flush;
    logic                     cdb_gnt;

    logic [NUM_REQ-1:0]       grant;
    logic                     start;
    logic [OP_W-1:0]          start_op;
    logic                     unit_kill;
    logic                     cdb_req;
    logic [TAG_W-1:0]         cdb_tag;
    logic                     busy;

    modport slave (
        input  req_valid, req_op, req_cls, req_tag, flush, cdb_gnt,
        output grant, start, start_op, unit_kill, cdb_req, cdb_tag, busy
    );

    modport master (
        output req_valid, req_op, req_cls, req_tag, flush, cdb_gnt,
        input  grant, start, start_op, unit_kill, cdb_req, cdb_tag, busy
    );
endinterface

// File: rtl/muldiv_scheduler.sv
// ---------------------------------------------------------------------------
// muldiv_scheduler
//   Issue scheduler for a single shared, non-pipelined MUL/DIV unit.
//   Round-robin picks one of NUM_REQ ready requesters, launches the op,
//   counts down its fixed latency, then holds the result on the CDB request
//   until granted. Branch flushes abort the op in flight.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : muldiv_if.slave (requester, datapath and CDB handshakes)
// ---------------------------------------------------------------------------
module muldiv_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int OP_W    = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         cls_q, cls_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx;
    logic [1:0]         win_cls;

    logic [NUM_REQ-1:0] grant;
    logic               start;
    logic [OP_W-1:0]    start_op;
    logic               unit_kill;
    logic               cdb_req;

    // The class is only needed at launch to load the counter; the latched
    // copy is kept for debug visibility of the op in flight.
    logic               unused_cls;
    assign unused_cls = ^cls_q;

    // Counter load value is latency-1: the load edge itself is the first
    // cycle of the latency.
    function automatic logic [6:0] lat_load(input logic [1:0] cls);
        case (cls)
            2'b00:   return 7'd3;   // MUL / MULH*
            2'b01:   return 7'd2;   // MULW
            2'b10:   return 7'd64;  // DIV* / REM*
            default: return 7'd32;  // DIV*W / REM*W
        endcase
    endfunction

    // Round-robin search starting one past the last winner.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = ptr_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign win_cls = bus.req_cls[int'(winner)*2 +: 2];

    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        tag_d     = tag_q;
        cls_d     = cls_q;
        grant     = '0;
        start     = 1'b0;
        start_op  = '0;
        unit_kill = 1'b0;
        cdb_req   = 1'b0;

        case (state_q)
            IDLE: begin
                // Grant/start are combinational from req_valid, so they are
                // gated by rst_n to stay quiet while reset is held.
                if (rst_n && !bus.flush && found) begin
                    grant[winner] = 1'b1;
                    start         = 1'b1;
                    start_op      = bus.req_op[int'(winner)*OP_W +: OP_W];
                    tag_d         = bus.req_tag[int'(winner)*TAG_W +: TAG_W];
                    cls_d         = win_cls;
                    cnt_d         = lat_load(win_cls);
                    ptr_d         = winner;
                    state_d       = EXEC;
                end
            end

            EXEC: begin
                if (bus.flush) begin
                    unit_kill = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q <= 7'd1) begin
                    // Counter reaches 0 on this edge; never decrement past it.
                    cnt_d   = '0;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end

            WB: begin
                cdb_req = 1'b1;
                // Flush takes priority; with or without cdb_gnt we leave.
                if (bus.flush || bus.cdb_gnt) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            tag_q   <= '0;
            cls_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
            cls_q   <= cls_d;
        end
    end

    assign bus.grant     = grant;
    assign bus.start     = start;
    assign bus.start_op  = start_op;
    assign bus.unit_kill = unit_kill;
    assign bus.cdb_req   = cdb_req;
    assign bus.cdb_tag   = tag_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_muldiv_scheduler
//   Self-checking bench for muldiv_scheduler. A transaction-level model
//   (op in flight, cycle its result becomes ready, round-robin pointer) is
//   compared against the DUT every cycle; directed scenarios add literal
//   expectations, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_muldiv_scheduler;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 5;
    localparam int OP_W    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    muldiv_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int latency(input logic [1:0] cls);
        case (cls)
            2'b00:   return 4;
            2'b01:   return 3;
            2'b10:   return 65;
            default: return 33;
        endcase
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    bit               m_busy  = 1'b0;
    int               m_ready = 0;
    int               m_ptr   = NUM_REQ - 1;
    logic [TAG_W-1:0] m_tag   = '0;
    int               cyc     = 0;

    initial begin
        int               w;
        logic [NUM_REQ-1:0] exp_grant;
        logic             exp_start, exp_kill, exp_cdb;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                m_busy = 1'b0;
                m_ptr  = NUM_REQ - 1;
                m_tag  = '0;
                check("rst_grant",   32'(bus.grant),     32'd0);
                check("rst_start",   32'(bus.start),     32'd0);
                check("rst_kill",    32'(bus.unit_kill), 32'd0);
                check("rst_cdb_req", 32'(bus.cdb_req),   32'd0);
                check("rst_cdb_tag", 32'(bus.cdb_tag),   32'd0);
                check("rst_busy",    32'(bus.busy),      32'd0);
            end else begin
                w = -1;
                if (!m_busy && !bus.flush) begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        if (w < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ])
                            w = (m_ptr + k) % NUM_REQ;
                    end
                end
                exp_grant = (w >= 0) ? NUM_REQ'(1 << w) : '0;
                exp_start = (w >= 0);
                exp_cdb   = m_busy && (cyc >= m_ready);
                exp_kill  = m_busy && (cyc < m_ready) && bus.flush;

                check("grant",     32'(bus.grant),     32'(exp_grant));
                check("start",     32'(bus.start),     32'(exp_start));
                check("unit_kill", 32'(bus.unit_kill), 32'(exp_kill));
                check("cdb_req",   32'(bus.cdb_req),   32'(exp_cdb));
                check("busy",      32'(bus.busy),      32'(m_busy));
                if (exp_start)
                    check("start_op", 32'(bus.start_op), 32'(bus.req_op[w*OP_W +: OP_W]));
                if (m_busy)
                    check("cdb_tag", 32'(bus.cdb_tag), 32'(m_tag));

                if (exp_start) begin
                    m_busy  = 1'b1;
                    m_tag   = bus.req_tag[w*TAG_W +: TAG_W];
                    m_ready = cyc + latency(bus.req_cls[w*2 +: 2]);
                    m_ptr   = w;
                end else if (m_busy && (bus.flush || (exp_cdb && bus.cdb_gnt))) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cls_all(input logic [1:0] c);
        for (int i = 0; i < NUM_REQ; i++) bus.req_cls[i*2 +: 2] = c;
    endtask

    task automatic set_fixed_fields();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_tag[i*TAG_W +: TAG_W] = TAG_W'(7 + 3*i);
            bus.req_op[i*OP_W +: OP_W]    = OP_W'(i + 1);
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.flush     = 1'b0;
        bus.cdb_gnt   = 1'b0;
        #3;
        check("lit_reset_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- directed scenarios + random run ----------------
    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_cls   = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.cdb_gnt   = 1'b0;
        set_fixed_fields();
        repeat (2) tick();

        // Single MUL from requester 0, tag 7.
        do_reset();
        set_cls_all(2'b00);
        bus.cdb_gnt = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            tick();
            bus.req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            #3;
            if (c == 0) begin
                check("lit_a_grant", 32'(bus.grant), 32'h1);
                check("lit_a_start", 32'(bus.start), 32'h1);
            end
            if (c == 4) begin
                check("lit_a_cdb_req", 32'(bus.cdb_req), 32'h1);
                check("lit_a_cdb_tag", 32'(bus.cdb_tag), 32'd7);
            end
            if (c == 5) check("lit_a_busy", 32'(bus.busy), 32'h0);
        end

        // All requesters ready, MULW, CDB always granted: rotate every 4 cycles.
        do_reset();
        set_cls_all(2'b01);
        bus.cdb_gnt = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            tick();
            bus.req_valid = 4'b1111;
            #3;
            check("lit_b_grant", 32'(bus.grant),
                  (c % 4 == 0) ? 32'(1 << ((c / 4) % 4)) : 32'h0);
        end
        tick();
        bus.req_valid = '0;

        // DIV from requester 1 flushed in cycle 20; next grant goes to 2.
        do_reset();
        set_cls_all(2'b10);
        bus.cdb_gnt = 1'b1;
        for (int c = 0; c <= 21; c++) begin
            tick();
            bus.flush = (c == 20);
            if (c == 21) set_cls_all(2'b00);
            bus.req_valid = (c == 0) ? 4'b0010 : ((c == 21) ? 4'b1111 : 4'b0000);
            #3;
            if (c <= 20) check("lit_c_no_cdb", 32'(bus.cdb_req), 32'h0);
            if (c == 20) check("lit_c_kill", 32'(bus.unit_kill), 32'h1);
            if (c == 21) begin
                check("lit_c_busy",  32'(bus.busy),  32'h0);
                check("lit_c_grant", 32'(bus.grant), 32'h4);
            end
        end
        tick();
        bus.req_valid = '0;
        repeat (6) tick();

        // WB stall for 5 cycles, flush+cdb_gnt in WB, flush alone in IDLE.
        do_reset();
        set_cls_all(2'b00);
        for (int c = 0; c <= 11; c++) begin
            tick();
            bus.req_valid = (c == 0) ? 4'b0001 : ((c >= 10) ? 4'b0010 : 4'b1111);
            bus.flush     = (c == 9) || (c == 10);
            bus.cdb_gnt   = (c == 9);
            #3;
            if (c >= 4 && c <= 8) begin
                check("lit_d_cdb_req", 32'(bus.cdb_req), 32'h1);
                check("lit_d_cdb_tag", 32'(bus.cdb_tag), 32'd7);
                check("lit_d_grant",   32'(bus.grant),   32'h0);
            end
            if (c == 10) begin
                check("lit_d_busy",       32'(bus.busy),  32'h0);
                check("lit_d_flush_idle", 32'(bus.grant), 32'h0);
            end
            if (c == 11) check("lit_d_grant_after", 32'(bus.grant), 32'h2);
        end
        tick();
        bus.req_valid = '0;
        bus.flush     = 1'b0;
        bus.cdb_gnt   = 1'b1;
        repeat (6) tick();

        // Reset mid-EXEC of a DIVW; requester 0 wins first after release.
        do_reset();
        set_cls_all(2'b11);
        bus.cdb_gnt = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            tick();
            if (c == 5) rst_n = 1'b0;
            if (c == 7) rst_n = 1'b1;
            bus.req_valid = (c == 0) ? 4'b0100 : ((c >= 6) ? 4'b1111 : 4'b0000);
            #3;
            if (c == 0) check("lit_e_grant0", 32'(bus.grant), 32'h4);
            if (c == 5) begin
                check("lit_e_rst_busy", 32'(bus.busy),      32'h0);
                check("lit_e_rst_kill", 32'(bus.unit_kill), 32'h0);
                check("lit_e_rst_tag",  32'(bus.cdb_tag),   32'h0);
            end
            if (c == 6) check("lit_e_rst_grant", 32'(bus.grant), 32'h0);
            if (c == 7) check("lit_e_grant_after", 32'(bus.grant), 32'h1);
        end

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst_n         = ($urandom_range(0, 599) != 0);
            bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom_range(1, 15));
            bus.req_op    = (NUM_REQ*OP_W)'($urandom);
            bus.req_tag   = (NUM_REQ*TAG_W)'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 9) < 7)
                    bus.req_cls[i*2 +: 2] = {1'b0, 1'($urandom_range(0, 1))};
                else
                    bus.req_cls[i*2 +: 2] = {1'b1, 1'($urandom_range(0, 1))};
            end
            bus.flush   = ($urandom_range(0, 39) == 0);
            bus.cdb_gnt = 1'($urandom_range(0, 1));
        end

        tick();
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.flush     = 1'b0;
        tick();
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
